// File: rtl/chunked_adder_sequencer.sv
// Multi-cycle wide adder: one shared CHUNK-bit slice adds the operands
// least significant chunk first, carrying between chunks in a register.
module chunked_adder_sequencer #(
  parameter int CHUNK  = 3,
  parameter int NCHUNK = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      abort,
  input  logic [CHUNK*NCHUNK-1:0]   a,
  input  logic [CHUNK*NCHUNK-1:0]   b,
  input  logic                      cin,
  output logic                      busy,
  output logic                      done,
  output logic [CHUNK*NCHUNK-1:0]   sum,
  output logic                      cout
);

  localparam int WIDTH = CHUNK * NCHUNK;
  localparam int IW    = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           state;
  logic [IW-1:0]    idx;
  logic             carry;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [CHUNK:0]   slice;

  // The single shared adder slice, steered by the chunk index.
  always_comb begin
    slice = {1'b0, a_reg[idx*CHUNK +: CHUNK]}
          + {1'b0, b_reg[idx*CHUNK +: CHUNK]}
          + {{CHUNK{1'b0}}, carry};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      idx   <= '0;
      carry <= 1'b0;
      a_reg <= '0;
      b_reg <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_reg <= a;
            b_reg <= b;
            carry <= cin;
            idx   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            busy  <= 1'b1;
            state <= S_RUN;
          end
        end

        S_RUN: begin
          // Abort wins over the chunk step, including the final one.
          if (abort) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
            carry <= 1'b0;
            idx   <= '0;
          end else begin
            sum[idx*CHUNK +: CHUNK] <= slice[CHUNK-1:0];
            carry <= slice[CHUNK];
            if (idx == IW'(NCHUNK - 1)) begin
              cout  <= slice[CHUNK];
              idx   <= '0;
              done  <= 1'b1;
              state <= S_DONE;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end

        S_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_chunked_adder_sequencer.sv
// Directed and randomised checks of chunked_adder_sequencer (CHUNK=3, NCHUNK=4).
module tb_chunked_adder_sequencer;

  localparam int CHUNK  = 3;
  localparam int NCHUNK = 4;
  localparam int WIDTH  = CHUNK * NCHUNK;

  logic             clk   = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic             cin   = 1'b0;
  logic [WIDTH-1:0] a     = '0;
  logic [WIDTH-1:0] b     = '0;
  logic             busy;
  logic             done;
  logic             cout;
  logic [WIDTH-1:0] sum;

  int n_compared    = 0;
  int n_mismatched  = 0;
  int done_seen     = 0;
  int done_expected = 0;

  chunked_adder_sequencer #(.CHUNK(CHUNK), .NCHUNK(NCHUNK)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .abort (abort),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (done) done_seen++;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_compared++;
    if (observed !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                               input logic cv, input logic sv, input logic ab);
    a     = av;
    b     = bv;
    cin   = cv;
    start = sv;
    abort = ab;
  endtask

  // Called right after a negedge with the DUT idle; returns one negedge into the following IDLE.
  task automatic runOp(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv, input logic cv,
                       input logic [WIDTH-1:0] exp_sum, input logic exp_cout, input logic abort_in_done);
    logic [31:0] full;
    int          done_k;
    full = {19'd0, exp_cout, exp_sum};
    applyStimulus(av, bv, cv, 1'b1, 1'b0);
    @(negedge clk);
    applyStimulus(~av, ~bv, ~cv, 1'b0, 1'b0);
    checkOutput("busy_after_accept", busy, 1);
    checkOutput("sum_cleared", sum, 0);
    checkOutput("done_early", done, 0);
    done_k = -1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (done) begin
        done_k = k;
        break;
      end
      if (k < NCHUNK) begin
        checkOutput("partial_sum", sum, full & ((32'd1 << (CHUNK * k)) - 1));
        checkOutput("busy_run", busy, 1);
      end
    end
    checkOutput("done_latency", done_k, NCHUNK);
    checkOutput("sum", sum, exp_sum);
    checkOutput("cout", cout, exp_cout);
    checkOutput("busy_in_done", busy, 1);
    done_expected++;
    if (abort_in_done) abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checkOutput("done_single_pulse", done, 0);
    checkOutput("busy_back_idle", busy, 0);
    checkOutput("sum_hold", sum, exp_sum);
    checkOutput("cout_hold", cout, exp_cout);
  endtask

  initial begin
    logic [WIDTH-1:0] ra, rb;
    logic             rc;
    logic [WIDTH:0]   rfull;

    repeat (2) @(negedge clk);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_done", done, 0);
    checkOutput("reset_sum", sum, 0);
    checkOutput("reset_cout", cout, 0);
    rst_n = 1'b1;
    @(negedge clk);

    runOp(12'h005, 12'h003, 1'b0, 12'h008, 1'b0, 1'b0);
    runOp(12'hFFF, 12'h001, 1'b0, 12'h000, 1'b1, 1'b0);
    runOp(12'hABC, 12'h543, 1'b1, 12'h000, 1'b1, 1'b0);
    runOp(12'hABC, 12'h543, 1'b0, 12'hFFF, 1'b0, 1'b1);

    // START held high while operands change: ignored until the first IDLE edge after DONE.
    applyStimulus(12'h123, 12'h456, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    applyStimulus(12'h111, 12'h222, 1'b0, 1'b1, 1'b0);
    repeat (NCHUNK) @(negedge clk);
    checkOutput("hold_done1", done, 1);
    checkOutput("hold_sum1", sum, 12'h579);
    done_expected++;
    @(negedge clk);
    checkOutput("hold_idle_busy", busy, 0);
    checkOutput("hold_sum1_kept", sum, 12'h579);
    @(negedge clk);
    checkOutput("hold_second_accept", busy, 1);
    applyStimulus(12'h000, 12'h000, 1'b0, 1'b0, 1'b0);
    repeat (NCHUNK) @(negedge clk);
    checkOutput("hold_done2", done, 1);
    checkOutput("hold_sum2", sum, 12'h333);
    checkOutput("hold_cout2", cout, 0);
    done_expected++;
    @(negedge clk);

    // Abort on the second RUN edge clears the partial result with no DONE.
    applyStimulus(12'h123, 12'h456, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    applyStimulus(12'h123, 12'h456, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("abort_partial", sum, 12'h001);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checkOutput("abort_busy", busy, 0);
    checkOutput("abort_done", done, 0);
    checkOutput("abort_sum", sum, 0);
    checkOutput("abort_cout", cout, 0);
    repeat (6) @(negedge clk);
    checkOutput("abort_still_idle", busy, 0);

    // START and ABORT together in IDLE: START wins.
    applyStimulus(12'h005, 12'h003, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    applyStimulus(12'h000, 12'h000, 1'b0, 1'b0, 1'b0);
    checkOutput("start_abort_busy", busy, 1);
    repeat (NCHUNK) @(negedge clk);
    checkOutput("start_abort_done", done, 1);
    checkOutput("start_abort_sum", sum, 12'h008);
    done_expected++;
    @(negedge clk);

    // Asynchronous reset mid-RUN.
    applyStimulus(12'h005, 12'h001, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    checkOutput("rst_partial", sum, 12'h006);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rst_async_busy", busy, 0);
    checkOutput("rst_async_sum", sum, 0);
    checkOutput("rst_async_cout", cout, 0);
    checkOutput("rst_async_done", done, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    checkOutput("rst_stays_idle", busy, 0);
    runOp(12'h7A5, 12'h15B, 1'b1, 12'h901, 1'b0, 1'b0);

    // Random back-to-back operations with small gaps.
    for (int i = 0; i < 1000; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      ra    = WIDTH'($urandom);
      rb    = WIDTH'($urandom);
      rc    = 1'($urandom);
      rfull = {1'b0, ra} + {1'b0, rb} + {{WIDTH{1'b0}}, rc};
      runOp(ra, rb, rc, rfull[WIDTH-1:0], rfull[WIDTH], (i % 7) == 0);
    end

    @(negedge clk);
    checkOutput("done_count", done_seen, done_expected);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
